// File: rtl/imm_extend_pipe.sv
// Purpose : decode/extend a 12-bit split immediate or a 20-bit upper immediate
//           from a 32-bit instruction word to XLEN bits, with a sideband tag.
// Latency : 1 cycle from input transfer to Out_Valid when the output stage
//           is empty or draining.
// Backpressure: valid/ready on both sides; an output register plus one skid
//           entry absorb a stall, and In_Ready drops while the skid is full.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   In, ImmSrc, Tag_In           instruction word, format select, sideband tag
//   In_Valid / In_Ready          input handshake (In_Ready is a flop output)
//   Imm_Ext, Tag_Out, Illegal    registered result, aligned tag, bad-format flag
//   Out_Valid / Out_Ready        output handshake
//   Illegal_Cnt                  saturating count of accepted illegal formats

module imm_extend_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      In,
   input  logic [2:0]       ImmSrc,
   input  logic [TAG_W-1:0] Tag_In,
   input  logic             In_Valid,
   output logic             In_Ready,
   output logic [XLEN-1:0]  Imm_Ext,
   output logic [TAG_W-1:0] Tag_Out,
   output logic             Illegal,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [CNT_W-1:0] Illegal_Cnt
);

   // ---------------------------------------------------------------
   // Input-side extension (combinational)
   // ---------------------------------------------------------------
   logic [11:0]     fld_s;   // {In[31:26], In[22:17]}
   logic [11:0]     fld_b;   // {In[31:26], In[10:5]}
   logic [31:0]     fld_u;   // upper immediate, low 12 bits cleared
   logic [XLEN-1:0] ext_imm;
   logic            ext_ill;

   assign fld_s = {In[31:26], In[22:17]};
   assign fld_b = {In[31:26], In[10:5]};
   assign fld_u = {In[31:12], 12'b0};

   // Instruction bits no format looks at.
   logic unused_in;
   assign unused_in = ^{In[11], In[4:0]};

   // A size cast of a signed operand sign-extends; of an unsigned one, zero-extends.
   always_comb begin
      ext_imm = '0;
      ext_ill = 1'b0;
      case (ImmSrc)
         3'b001:  ext_imm = XLEN'($signed(fld_s));
         3'b010:  ext_imm = XLEN'($signed(fld_b));
         3'b011:  ext_imm = XLEN'(fld_s);
         3'b100:  ext_imm = XLEN'(fld_b);
         3'b101:  ext_imm = XLEN'($signed(fld_u));
         default: ext_ill = 1'b1;   // 000, 110, 111
      endcase
   end

   // ---------------------------------------------------------------
   // Output register + skid register
   // ---------------------------------------------------------------
   logic             out_vld;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             out_ill;

   logic             skid_vld;
   logic [XLEN-1:0]  skid_imm;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_ill;

   logic             in_rdy_q;   // always equals !skid_vld, kept as its own flop
   logic [CNT_W-1:0] ill_cnt;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = In_Valid & in_rdy_q;
   assign out_xfer = out_vld & Out_Ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_imm  <= '0;
         out_tag  <= '0;
         out_ill  <= 1'b0;
         skid_vld <= 1'b0;
         skid_imm <= '0;
         skid_tag <= '0;
         skid_ill <= 1'b0;
         in_rdy_q <= 1'b1;
         ill_cnt  <= '0;
      end else begin
         if (out_xfer) begin
            if (skid_vld) begin
               // In_Ready was low, so no input can arrive in this cycle.
               out_imm  <= skid_imm;
               out_tag  <= skid_tag;
               out_ill  <= skid_ill;
               skid_vld <= 1'b0;
               in_rdy_q <= 1'b1;
            end else if (in_xfer) begin
               out_imm <= ext_imm;
               out_tag <= Tag_In;
               out_ill <= ext_ill;
            end else begin
               out_vld <= 1'b0;
            end
         end else if (in_xfer) begin
            if (!out_vld) begin
               out_vld <= 1'b1;
               out_imm <= ext_imm;
               out_tag <= Tag_In;
               out_ill <= ext_ill;
            end else begin
               // Output is stalled: park the new entry in the skid.
               skid_vld <= 1'b1;
               skid_imm <= ext_imm;
               skid_tag <= Tag_In;
               skid_ill <= ext_ill;
               in_rdy_q <= 1'b0;
            end
         end

         if (in_xfer && ext_ill && (ill_cnt != '1))
            ill_cnt <= ill_cnt + CNT_W'(1);
      end
   end

   assign In_Ready    = in_rdy_q;
   assign Out_Valid   = out_vld;
   assign Imm_Ext     = out_imm;
   assign Tag_Out     = out_tag;
   assign Illegal     = out_ill;
   assign Illegal_Cnt = ill_cnt;

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning extended-immediate width; legal values are 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 5, meaning width of the sideband tag carried with each immediate.
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of the illegal-encoding counter.
REQ-004 SHALL have the following ports; there is one clock, and reset is synchronous and active-high:
  clk  input  1  clock
  rst  input  1  synchronous active-high reset
  In  input  32  instruction word
  ImmSrc  input  3  immediate format select
  Tag_In  input  TAG_W  sideband tag
  In_Valid  input  1  input transfer offered
  In_Ready  output  1  block can accept
  Imm_Ext  output  XLEN  extended immediate
  Tag_Out  output  TAG_W  tag aligned with Imm_Ext
  Illegal  output  1  ImmSrc of current output was unsupported
  Out_Valid  output  1  output transfer offered
  Out_Ready  input  1  consumer accepts
  Illegal_Cnt  output  CNT_W  saturating count of illegal encodings accepted

Function
REQ-005 Input transfer SHALL occur when In_Valid and In_Ready are both 1 on a rising clk edge; output transfer SHALL occur when Out_Valid and Out_Ready are both 1.
REQ-006 ImmSrc=001 SHALL produce {In[31:26], In[22:17]} sign-extended from In[31] to XLEN bits.
REQ-007 ImmSrc=010 SHALL produce {In[31:26], In[10:5]} sign-extended from In[31] to XLEN bits.
REQ-008 ImmSrc=011 SHALL produce the REQ-006 field zero-extended, and ImmSrc=100 SHALL produce the REQ-007 field zero-extended.
REQ-009 ImmSrc=101 SHALL produce {In[31:12], 12'b0} sign-extended from In[31] to XLEN bits.
REQ-010 ImmSrc 000, 110 and 111 SHALL produce Imm_Ext=0 with Illegal=1; every other code SHALL produce Illegal=0.
REQ-011 Extension SHALL be computed on the input side and registered; latency from input transfer to Out_Valid SHALL be exactly 1 cycle when the output stage is empty or draining.
REQ-012 Storage SHALL be one output register plus one skid register, each holding {Imm_Ext, Tag_Out, Illegal}.
REQ-013 In_Ready SHALL equal NOT skid_valid, registered so that it depends on no input in the same cycle.
REQ-014 On input transfer with Out_Valid=0, or with Out_Valid=1 and Out_Ready=1: data SHALL load the output register.
REQ-015 On input transfer with Out_Valid=1 and Out_Ready=0: data SHALL load the skid register, and In_Ready SHALL be 0 from the next cycle.
REQ-016 On output transfer with skid valid: skid contents SHALL move to the output register, the skid SHALL clear, and In_Ready SHALL return to 1 the next cycle.
REQ-017 On output transfer with no input transfer and an empty skid: Out_Valid SHALL fall to 0 the next cycle.
REQ-018 Transfer order SHALL be preserved; no transfer SHALL be dropped or duplicated.
REQ-019 Output register contents SHALL be stable while Out_Valid=1 and Out_Ready=0.
REQ-020 Illegal_Cnt SHALL increment by 1 on each input transfer with an illegal ImmSrc, SHALL saturate at all-ones, and SHALL never wrap.
REQ-021 Inputs without a transfer (In_Valid=0, or In_Ready=0) SHALL NOT change any state.

Reset
REQ-022 While rst=1 at a clk edge: Out_Valid, skid_valid, Imm_Ext, Tag_Out, Illegal and Illegal_Cnt SHALL become 0, and In_Ready SHALL become 1.
REQ-023 Reset SHALL take priority over any simultaneous transfer, and all in-flight entries SHALL be discarded.

Verification
REQ-024 Bench: In=32'h04020000, ImmSrc=001, Out_Ready=1 -> one cycle later Out_Valid=1, Imm_Ext=32'h00000041, Illegal=0.
REQ-025 Bench: In=32'h800003E0 with ImmSrc=010 -> Imm_Ext=32'hFFFFF81F; with ImmSrc=100 -> 32'h0000081F; In=32'h12345ABC with ImmSrc=101 -> 32'h12345000.
REQ-026 Bench: Out_Ready=0 and three back-to-back offers with tags 1,2,3 -> In_Ready=0 after tag 2 is accepted and tag 3 is held; then Out_Ready=1 -> Tag_Out sequence is 1,2,3 on consecutive cycles.
REQ-027 Bench: 260 transfers with ImmSrc=111 -> each output has Imm_Ext=0 and Illegal=1, and Illegal_Cnt=8'hFF (saturated).
REQ-028 Bench: both stages full, then rst=1 for one cycle -> next cycle Out_Valid=0, In_Ready=1, Illegal_Cnt=0, and the next accepted transfer appears correctly after 1 cycle.
REQ-029 Bench: XLEN=64, In=32'h800003E0, ImmSrc=010 -> Imm_Ext=64'hFFFFFFFFFFFFF81F.
